// File: rtl/dk_hs_pkg.sv
// Shared types and window constants for the hiscore RAM port.
// Variants with a different RAM map override the window parameters at instantiation.
package dk_hs_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    GRANT,
    RELEASE,
    FAIL
  } hs_state_t;

  localparam logic [15:0] WIN_BASE_DEF = 16'h6000;
  localparam logic [15:0] WIN_SIZE_DEF = 16'h0800;
  localparam logic [7:0]  HS_OOW_DATA  = 8'hFF;

endpackage

// File: rtl/hs_win_decode.sv
// Maps a hiscore CPU-space address onto the work RAM window.
// The wrapping 16-bit difference makes addresses below the base land out of window too.
module hs_win_decode
  import dk_hs_pkg::*;
#(
  parameter int unsigned RAM_AW   = 11,
  parameter logic [15:0] WIN_BASE = WIN_BASE_DEF,
  parameter logic [15:0] WIN_SIZE = WIN_SIZE_DEF
) (
  input  logic [15:0]       hs_address,
  output logic [RAM_AW-1:0] offset,
  output logic              in_win
);

  logic [15:0] diff;

  assign diff   = hs_address - WIN_BASE;
  assign in_win = (diff < WIN_SIZE);
  assign offset = diff[RAM_AW-1:0];

endmodule

// File: rtl/hs_ram_port.sv
// Game-side hiscore responder: pauses the CPU, then hands the work RAM to the hiscore
// engine through a registered address stage; the CPU passes straight through otherwise.
module hs_ram_port
  import dk_hs_pkg::*;
#(
  parameter int unsigned RAM_AW      = 11,
  parameter logic [15:0] WIN_BASE    = WIN_BASE_DEF,
  parameter logic [15:0] WIN_SIZE    = WIN_SIZE_DEF,
  parameter int unsigned ACK_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RAM_AW-1:0] cpu_addr,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  input  logic              cpu_halt_ack,
  output logic              pause_req,
  input  logic              hs_access,
  input  logic [15:0]       hs_address,
  input  logic              hs_write,
  input  logic [7:0]        hs_data_in,
  output logic [7:0]        hs_data_out,
  output logic              hs_grant,
  output logic              hs_error,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  localparam int unsigned      CNT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  hs_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [RAM_AW-1:0] win_offset;
  logic              win_in;
  logic              capture;

  // Stage 1 drives the RAM; stage 2 waits for the synchronous read data.
  logic              s1_we_q, s1_rd_q, s1_oow_q;
  logic [RAM_AW-1:0] s1_addr_q;
  logic [7:0]        s1_wdata_q;
  logic              s2_rd_q, s2_oow_q;

  hs_win_decode #(
    .RAM_AW   (RAM_AW),
    .WIN_BASE (WIN_BASE),
    .WIN_SIZE (WIN_SIZE)
  ) u_win_decode (
    .hs_address (hs_address),
    .offset     (win_offset),
    .in_win     (win_in)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (hs_access) begin
          state_d = REQ;
          cnt_d   = '0;
        end
      end
      REQ: begin
        if (!hs_access) begin
          state_d = RELEASE;
        end else if (cpu_halt_ack) begin
          state_d = GRANT;
        end else if (cnt_q == CNT_LAST) begin
          state_d = FAIL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // A dropped ack is ignored here: ownership lasts until hs_access falls.
      GRANT:   if (!hs_access) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      FAIL:    if (!hs_access) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    pause_req = 1'b0;
    hs_grant  = 1'b0;
    hs_error  = 1'b0;
    unique case (state_q)
      REQ:   pause_req = 1'b1;
      GRANT: begin
        pause_req = 1'b1;
        hs_grant  = 1'b1;
      end
      FAIL:    hs_error = 1'b1;
      default: ;
    endcase
  end

  assign capture = (state_q == GRANT) && hs_access;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_we_q     <= 1'b0;
      s1_rd_q     <= 1'b0;
      s1_oow_q    <= 1'b0;
      s1_addr_q   <= '0;
      s1_wdata_q  <= '0;
      s2_rd_q     <= 1'b0;
      s2_oow_q    <= 1'b0;
      hs_data_out <= HS_OOW_DATA;
    end else begin
      s1_we_q    <= capture && hs_write && win_in;
      s1_rd_q    <= capture && !hs_write;
      s1_oow_q   <= !win_in;
      s1_addr_q  <= win_offset;
      s1_wdata_q <= hs_data_in;
      s2_rd_q    <= s1_rd_q;
      s2_oow_q   <= s1_oow_q;
      if (s2_rd_q) begin
        hs_data_out <= s2_oow_q ? HS_OOW_DATA : ram_rdata;
      end
    end
  end

  // A capture always lands in GRANT, so a write registered on the last cycle still completes.
  always_comb begin
    if (state_q == GRANT) begin
      ram_addr  = s1_addr_q;
      ram_we    = s1_we_q;
      ram_wdata = s1_wdata_q;
    end else begin
      ram_addr  = cpu_addr;
      ram_we    = cpu_cs & cpu_we;
      ram_wdata = cpu_wdata;
    end
  end

  assign cpu_rdata = ram_rdata;

endmodule

// File: tb/tb_hs_ram_port.sv
// Directed bench for hs_ram_port with a behavioural synchronous 2 KB RAM.
module tb_hs_ram_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] cpu_addr;
  logic        cpu_cs, cpu_we;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_halt_ack, pause_req;
  logic        hs_access;
  logic [15:0] hs_address;
  logic        hs_write;
  logic [7:0]  hs_data_in, hs_data_out;
  logic        hs_grant, hs_error;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  logic [7:0]  mem [2048];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  hs_ram_port #(
    .RAM_AW      (11),
    .WIN_BASE    (16'h6000),
    .WIN_SIZE    (16'h0800),
    .ACK_TIMEOUT (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_cs       (cpu_cs),
    .cpu_we       (cpu_we),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_halt_ack (cpu_halt_ack),
    .pause_req    (pause_req),
    .hs_access    (hs_access),
    .hs_address   (hs_address),
    .hs_write     (hs_write),
    .hs_data_in   (hs_data_in),
    .hs_data_out  (hs_data_out),
    .hs_grant     (hs_grant),
    .hs_error     (hs_error),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [10:0] a, input logic [7:0] d);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_cs    = 1'b1;
    cpu_we    = 1'b1;
    tick();
    cpu_cs    = 1'b0;
    cpu_we    = 1'b0;
  endtask

  task automatic hs_drive(input logic [15:0] a, input logic w, input logic [7:0] d);
    hs_address = a;
    hs_write   = w;
    hs_data_in = d;
  endtask

  initial begin
    reset        = 1'b1;
    cpu_addr     = '0;
    cpu_cs       = 1'b0;
    cpu_we       = 1'b0;
    cpu_wdata    = '0;
    cpu_halt_ack = 1'b0;
    hs_access    = 1'b0;
    hs_address   = '0;
    hs_write     = 1'b0;
    hs_data_in   = '0;
    #2;
    check("rst_pause", 16'(pause_req), 16'h0);
    check("rst_grant", 16'(hs_grant), 16'h0);
    check("rst_error", 16'(hs_error), 16'h0);
    check("rst_dout", 16'(hs_data_out), 16'h00FF);
    tick();
    reset = 1'b0;

    // Preload through the CPU pass-through path
    cpu_write(11'h010, 8'h11);
    cpu_write(11'h011, 8'h22);
    cpu_write(11'h012, 8'h33);
    cpu_write(11'h000, 8'h00);
    cpu_write(11'h100, 8'h4C);

    // CPU pass-through
    cpu_addr  = 11'h123;
    cpu_wdata = 8'h5A;
    cpu_cs    = 1'b1;
    cpu_we    = 1'b1;
    #1;
    check("pt_we", 16'(ram_we), 16'h1);
    check("pt_addr", 16'(ram_addr), 16'h0123);
    tick();
    cpu_we = 1'b0;
    tick();
    check("pt_rdata", 16'(cpu_rdata), 16'h005A);
    check("pt_pause", 16'(pause_req), 16'h0);
    cpu_cs = 1'b0;

    // Grant handshake
    hs_drive(16'h6010, 1'b0, 8'h00);
    hs_access = 1'b1;
    #1;
    check("hs_pause_pre", 16'(pause_req), 16'h0);
    tick();
    check("hs_pause_rise", 16'(pause_req), 16'h1);
    check("hs_grant_req", 16'(hs_grant), 16'h0);
    repeat (4) tick();
    cpu_halt_ack = 1'b1;
    #1;
    check("hs_grant_pre", 16'(hs_grant), 16'h0);
    tick();
    check("hs_grant_rise", 16'(hs_grant), 16'h1);
    check("hs_grant_pause", 16'(pause_req), 16'h1);

    // Pipelined reads, window boundaries and CPU masking (C0..C9 in GRANT)
    tick(); hs_drive(16'h6011, 1'b0, 8'h00);                    // C1
    tick(); hs_drive(16'h6012, 1'b0, 8'h00);                    // C2
    tick(); hs_drive(16'h5FFF, 1'b0, 8'h00);                    // C3
    check("rd_0x010", 16'(hs_data_out), 16'h0011);
    tick(); hs_drive(16'h67FF, 1'b1, 8'hA5);                    // C4
    check("rd_0x011", 16'(hs_data_out), 16'h0022);
    tick(); hs_drive(16'h6800, 1'b1, 8'h3C);                    // C5
    check("rd_0x012", 16'(hs_data_out), 16'h0033);
    check("wr_top_we", 16'(ram_we), 16'h1);
    check("wr_top_addr", 16'(ram_addr), 16'h07FF);
    tick(); hs_drive(16'h67FF, 1'b0, 8'h00);                    // C6
    cpu_addr  = 11'h000;
    cpu_wdata = 8'hEE;
    cpu_cs    = 1'b1;
    cpu_we    = 1'b1;
    #1;
    check("rd_oow_low", 16'(hs_data_out), 16'h00FF);
    check("oow_cpu_we", 16'(ram_we), 16'h0);
    check("mem_7ff", 16'(mem[11'h7FF]), 16'h00A5);
    tick();                                                     // C7
    cpu_cs = 1'b0;
    cpu_we = 1'b0;
    check("mem_000", 16'(mem[11'h000]), 16'h0000);
    tick();                                                     // C8
    check("dout_hold", 16'(hs_data_out), 16'h00FF);
    tick();                                                     // C9
    check("rd_0x7ff", 16'(hs_data_out), 16'h00A5);
    hs_access = 1'b0;
    tick();
    check("rel_grant", 16'(hs_grant), 16'h0);
    check("rel_pause", 16'(pause_req), 16'h0);
    cpu_halt_ack = 1'b0;
    tick();
    cpu_addr = 11'h055;
    #1;
    check("idle_mux", 16'(ram_addr), 16'h0055);

    // Acknowledge timeout
    hs_access = 1'b1;
    tick();
    repeat (15) tick();
    check("to_req_last", 16'(pause_req), 16'h1);
    check("to_err_pre", 16'(hs_error), 16'h0);
    tick();
    check("to_error", 16'(hs_error), 16'h1);
    check("to_pause", 16'(pause_req), 16'h0);
    check("to_grant", 16'(hs_grant), 16'h0);
    tick();
    check("to_sticky", 16'(hs_error), 16'h1);
    hs_access = 1'b0;
    tick();
    check("to_clear", 16'(hs_error), 16'h0);
    check("to_idle_pause", 16'(pause_req), 16'h0);

    // Reset mid-GRANT with a write pending in the address stage
    hs_access = 1'b1;
    hs_drive(16'h6100, 1'b1, 8'h77);
    tick();
    cpu_halt_ack = 1'b1;
    tick();
    check("rg_grant", 16'(hs_grant), 16'h1);
    tick();
    check("rg_pend_we", 16'(ram_we), 16'h1);
    #2;
    reset = 1'b1;
    #1;
    check("rg_pause", 16'(pause_req), 16'h0);
    check("rg_grant_fall", 16'(hs_grant), 16'h0);
    check("rg_we", 16'(ram_we), 16'h0);
    tick();
    reset        = 1'b0;
    cpu_halt_ack = 1'b0;
    hs_write     = 1'b0;
    check("rg_mem_100", 16'(mem[11'h100]), 16'h004C);
    tick();
    check("rg_req_pause", 16'(pause_req), 16'h1);
    check("rg_req_grant", 16'(hs_grant), 16'h0);
    cpu_halt_ack = 1'b1;
    tick();
    check("rg_regrant", 16'(hs_grant), 16'h1);
    hs_access = 1'b0;
    tick();
    tick();
    check("rg_end_pause", 16'(pause_req), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
